// File: rtl/ttl_74x148_irq_encoder_pkg.sv
// Shared definitions for the clocked TTL models.
//   state_t  : two-state grant FSM encoding (IDLE/HOLD)
//   penc_t   : result of a priority encode (valid flag + index)
//   prio_enc : index of the highest set bit of a vector up to MAX_W bits
package ttl_74x148_irq_encoder_pkg;

    localparam int MAX_W   = 256;
    localparam int MAX_IDX = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDX-1:0] idx;
    } penc_t;

    // Scans upward, so the last (highest) set bit wins.
    function automatic penc_t prio_enc(input logic [MAX_W-1:0] v);
        penc_t r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = MAX_IDX'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ttl_74x148_irq_encoder_if.sv
// Request/grant bus of the 74x148-style interrupt encoder.
//   EI_n : active-low enable in (sync)      I_n  : active-low requests (async)
//   ACK  : grant acknowledge (sync)         A_n  : active-low held code
//   GS_n : low while a code is held         EO_n : low when enabled and idle
// master = request source / consumer side, slave = encoder.
interface ttl_74x148_irq_encoder_if #(
    parameter int WIDTH = 8
);
    localparam int CODE_WIDTH = $clog2(WIDTH);

    logic                  EI_n;
    logic [WIDTH-1:0]      I_n;
    logic                  ACK;
    logic [CODE_WIDTH-1:0] A_n;
    logic                  GS_n;
    logic                  EO_n;

    modport master (
        output EI_n, I_n, ACK,
        input  A_n, GS_n, EO_n
    );

    modport slave (
        input  EI_n, I_n, ACK,
        output A_n, GS_n, EO_n
    );
endinterface

// File: rtl/ttl_74x148_irq_encoder_sync2_bank.sv
// ttl_sync2_bank: WIDTH-bit two-flop synchronizer.
//   i_clk   : clock            i_rst_n : async active-low reset (to all ones)
//   i_d     : async inputs     o_q     : synchronized outputs
// Resets high so active-low TTL lines read as idle after reset.
module ttl_sync2_bank #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;
endmodule

// File: rtl/ttl_74x148_irq_encoder.sv
// Clocked 74x148-style priority interrupt encoder.
//   CLK   : clock               RST_n : async active-low reset
//   irq   : slave side of the request/grant bus (EI_n, I_n, ACK in;
//           A_n, GS_n, EO_n out)
// Falling edges on I_n latch pending bits; the highest pending index is
// granted on A_n/GS_n and held until ACK (or dropped on EI_n=1).
module ttl_74x148_irq_encoder
    import ttl_74x148_irq_encoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RST_n,
    ttl_74x148_irq_encoder_if.slave     irq
);
    localparam int CODE_WIDTH = $clog2(WIDTH);

    logic [WIDTH-1:0]      w_sync;
    logic [WIDTH-1:0]      r_hist;
    logic [WIDTH-1:0]      r_pend;
    logic [WIDTH-1:0]      w_pend_nxt;
    logic [WIDTH-1:0]      w_fall;
    logic [WIDTH-1:0]      w_clr;
    logic [MAX_W-1:0]      w_pend_ext;
    penc_t                 w_enc;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CODE_WIDTH-1:0] r_code;
    logic [CODE_WIDTH-1:0] w_code_nxt;
    logic                  w_ack_take;
    logic [CODE_WIDTH-1:0] r_a_n;
    logic                  r_gs_n;
    logic                  r_eo_n;

    ttl_sync2_bank #(.WIDTH(WIDTH)) u_sync (
        .i_clk   (CLK),
        .i_rst_n (RST_n),
        .i_d     (irq.I_n),
        .o_q     (w_sync)
    );

    assign w_fall = r_hist & ~w_sync;

    always_comb begin
        w_pend_ext             = '0;
        w_pend_ext[WIDTH-1:0]  = r_pend;
    end

    assign w_enc = prio_enc(w_pend_ext);

    // EI_n=1 beats ACK, so an aborted grant keeps its pending bit.
    assign w_ack_take = (r_state == HOLD) && irq.ACK && !irq.EI_n;
    assign w_clr      = w_ack_take ? (WIDTH'(1) << r_code) : '0;
    // A new edge in the same cycle as its clear wins.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_fall;

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        case (r_state)
            IDLE: begin
                if (!irq.EI_n && w_enc.valid) begin
                    w_state_nxt = HOLD;
                    w_code_nxt  = CODE_WIDTH'(w_enc.idx);
                end
            end
            HOLD: begin
                if (irq.EI_n || irq.ACK) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the FSM.
    // Leaving HOLD always passes through IDLE, giving one GS_n-high cycle.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_hist  <= '1;
            r_pend  <= '0;
            r_state <= IDLE;
            r_code  <= '0;
            r_a_n   <= '1;
            r_gs_n  <= 1'b1;
            r_eo_n  <= 1'b1;
        end else begin
            r_hist  <= w_sync;
            r_pend  <= w_pend_nxt;
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_a_n   <= (w_state_nxt == HOLD) ? ~w_code_nxt : '1;
            r_gs_n  <= (w_state_nxt != HOLD);
            r_eo_n  <= !(!irq.EI_n && (w_pend_nxt == '0) && (w_state_nxt == IDLE));
        end
    end

    assign irq.A_n  = r_a_n;
    assign irq.GS_n = r_gs_n;
    assign irq.EO_n = r_eo_n;
endmodule

// File: tb/tb_ttl_74x148_irq_encoder.sv
module tb_ttl_74x148_irq_encoder;
    logic CLK = 1'b0;
    logic RST_n;
    int   ntest = 0;
    int   nfail = 0;

    ttl_74x148_irq_encoder_if #(.WIDTH(8)) irq ();

    ttl_74x148_irq_encoder #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .irq   (irq.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack_pulse();
        irq.ACK = 1'b1;
        tick();
        irq.ACK = 1'b0;
    endtask

    initial begin
        RST_n    = 1'b0;
        irq.EI_n = 1'b0;
        irq.I_n  = 8'hFF;
        irq.ACK  = 1'b0;
        tick(2);
        RST_n = 1'b1;
        tick(3);

        // Reset asserted between edges acts immediately
        #2 RST_n = 1'b0;
        #1;
        chk("rst_a", {5'd0, irq.A_n}, 8'h07);
        chk("rst_gs", {7'd0, irq.GS_n}, 8'h01);
        chk("rst_eo", {7'd0, irq.EO_n}, 8'h01);
        tick(2);
        RST_n = 1'b1;
        tick();
        chk("rel_eo", {7'd0, irq.EO_n}, 8'h00);
        chk("rel_gs", {7'd0, irq.GS_n}, 8'h01);

        // Single request on line 5: grant at edge 3
        irq.I_n[5] = 1'b0;
        tick(3);
        chk("s5_e2_gs", {7'd0, irq.GS_n}, 8'h01);
        tick();
        chk("s5_gs", {7'd0, irq.GS_n}, 8'h00);
        chk("s5_a", {5'd0, irq.A_n}, 8'h02);
        chk("s5_eo", {7'd0, irq.EO_n}, 8'h01);
        tick(5);
        chk("s5_hold_gs", {7'd0, irq.GS_n}, 8'h00);
        chk("s5_hold_a", {5'd0, irq.A_n}, 8'h02);
        ack_pulse();
        chk("s5_ack_a", {5'd0, irq.A_n}, 8'h07);
        chk("s5_ack_gs", {7'd0, irq.GS_n}, 8'h01);
        tick();
        chk("s5_ack_eo", {7'd0, irq.EO_n}, 8'h00);
        irq.I_n[5] = 1'b1;
        tick(3);

        // Lines 2 and 6 together: 6 first, one idle cycle, then 2
        irq.I_n[2] = 1'b0;
        irq.I_n[6] = 1'b0;
        tick(4);
        chk("p6_gs", {7'd0, irq.GS_n}, 8'h00);
        chk("p6_a", {5'd0, irq.A_n}, 8'h01);
        ack_pulse();
        chk("p_gap_gs", {7'd0, irq.GS_n}, 8'h01);
        tick();
        chk("p2_gs", {7'd0, irq.GS_n}, 8'h00);
        chk("p2_a", {5'd0, irq.A_n}, 8'h05);
        ack_pulse();
        chk("p2_ack_a", {5'd0, irq.A_n}, 8'h07);
        irq.I_n = 8'hFF;
        tick(3);

        // Line 3 held low: one grant only, then re-arm on a fresh fall
        irq.I_n[3] = 1'b0;
        tick(4);
        chk("l3_a", {5'd0, irq.A_n}, 8'h04);
        ack_pulse();
        tick(5);
        chk("l3_nore_gs", {7'd0, irq.GS_n}, 8'h01);
        chk("l3_nore_eo", {7'd0, irq.EO_n}, 8'h00);
        irq.I_n[3] = 1'b1;
        tick(3);
        irq.I_n[3] = 1'b0;
        tick(4);
        chk("l3_re_gs", {7'd0, irq.GS_n}, 8'h00);
        chk("l3_re_a", {5'd0, irq.A_n}, 8'h04);
        ack_pulse();
        irq.I_n[3] = 1'b1;
        tick(3);

        // Line 4: new synchronized fall lands on the ACK edge
        irq.I_n[4] = 1'b0;
        tick(4);
        chk("c4_a", {5'd0, irq.A_n}, 8'h03);
        irq.I_n[4] = 1'b1;
        tick(3);
        irq.I_n[4] = 1'b0;
        tick(2);
        ack_pulse();
        chk("c4_gap_gs", {7'd0, irq.GS_n}, 8'h01);
        tick();
        chk("c4_re_gs", {7'd0, irq.GS_n}, 8'h00);
        chk("c4_re_a", {5'd0, irq.A_n}, 8'h03);
        ack_pulse();
        tick();
        chk("c4_done_gs", {7'd0, irq.GS_n}, 8'h01);
        irq.I_n[4] = 1'b1;
        tick(3);

        // Abort code 7 via EI_n, then re-grant
        irq.I_n[7] = 1'b0;
        tick(4);
        chk("a7_a", {5'd0, irq.A_n}, 8'h00);
        irq.EI_n = 1'b1;
        irq.ACK  = 1'b1;   // EI_n beats ACK: pending must survive
        tick();
        irq.ACK  = 1'b0;
        chk("a7_ab_gs", {7'd0, irq.GS_n}, 8'h01);
        chk("a7_ab_a", {5'd0, irq.A_n}, 8'h07);
        chk("a7_ab_eo", {7'd0, irq.EO_n}, 8'h01);
        tick(2);
        chk("a7_ab2_gs", {7'd0, irq.GS_n}, 8'h01);
        irq.EI_n = 1'b0;
        tick();
        chk("a7_re_gs", {7'd0, irq.GS_n}, 8'h00);
        chk("a7_re_a", {5'd0, irq.A_n}, 8'h00);
        ack_pulse();
        chk("a7_ack_gs", {7'd0, irq.GS_n}, 8'h01);
        chk("a7_ack_eo", {7'd0, irq.EO_n}, 8'h00);

        // ACK in IDLE has no effect
        ack_pulse();
        tick();
        chk("idle_ack_gs", {7'd0, irq.GS_n}, 8'h01);
        chk("idle_ack_a", {5'd0, irq.A_n}, 8'h07);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/ttl_74x148_irq_encoder.md
Name: ttl_74x148_irq_encoder

Overview:
- Clocked, parameterized 74LS148-style priority encoder: the encode side paired with our active-low 2-to-4 decoders.
- Latches falling-edge requests on WIDTH active-low lines and presents the highest-numbered pending request as an active-low code.
- Holds that code until the consumer acknowledges it.
- Sits between asynchronous TTL-style request sources and a decoder or CPU that services one request at a time. Supports 148-style cascading through EI_n/EO_n.

Parameters:
- WIDTH, 8, number of request inputs; legal range 2..256.
- CODE_WIDTH, $clog2(WIDTH), width of the encoded output. Derived as a localparam and not overridable.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- EI_n  input  1  active-low enable input, synchronous to CLK.
- I_n  input  WIDTH  active-low request lines, asynchronous to CLK.
- ACK  input  1  active-high acknowledge, synchronous, one cycle per grant.
- A_n  output  CODE_WIDTH  active-low encoded index of the held request.
- GS_n  output  1  active-low group select; low while a code is held on A_n.
- EO_n  output  1  active-low enable output; low when enabled with nothing pending.

Behaviour:
- Reset (async assert, sync release):
  - A_n = all ones, GS_n = 1, EO_n = 1.
  - pending = 0, state = IDLE.
  - Synchronizer and history flops = all ones, so no spurious edge is seen after reset.
- Input path:
  - I_n passes through a 2-flop synchronizer, then a history flop.
  - Pending bit k sets on the cycle sync2[k]=0 and hist[k]=1, i.e. a falling edge.
  - A line held low never re-triggers.
  - Pulses shorter than 2 CLK periods may be missed; this is accepted.
- Latency: an I_n[k] fall meeting setup before edge 0 sets pending[k] at edge 2. GS_n goes low at edge 3 when the FSM is idle and EI_n=0.
- FSM has two states:
  - IDLE:
    - A_n = all ones, GS_n = 1.
    - If EI_n=0 and pending!=0: capture code = highest set index, drive A_n = ~code and GS_n = 0 (registered), go to HOLD.
  - HOLD:
    - A_n and GS_n stay stable.
    - On ACK=1: clear pending[code], go to IDLE. A_n returns to all ones and GS_n to 1 at that edge.
    - If EI_n=1 (abort): go to IDLE without clearing pending; the code is re-granted when EI_n returns low.
    - EI_n=1 takes priority over ACK in the same cycle.
- Spacing: GS_n stays high for at least one full cycle between consecutive grants.
- Pending changes during HOLD: a higher-priority request that arrives during HOLD does not pre-empt. It is granted after the current ACK.
- Same-cycle set and clear: if an edge on bit code arrives in the cycle its ACK clears it, set wins and pending[code] remains 1.
- ACK while in IDLE is ignored.
- EO_n (registered) = 0 iff EI_n=0, pending=0 and state=IDLE; otherwise 1.
- WIDTH not a power of two: codes >= WIDTH are never produced.
- Reset asserted mid-HOLD: all outputs go to reset values immediately and the held request is discarded.

Decomposition:
- Shared TTL package:
  - FSM state encoding (IDLE=1'b0, HOLD=1'b1).
  - A priority-encode function (vector -> index of highest set bit, plus valid flag).
- Sub-module ttl_sync2_bank: parameterized WIDTH-bit 2-flop synchronizer with async active-low reset to all ones. It is reused by other clocked TTL models.

Test Plan (WIDTH=8):
- Reset and idle:
  - Stimulus: RST_n=0 mid-sim, then release with I_n=8'hFF and EI_n=0.
  - Response: during reset A_n=3'b111, GS_n=1, EO_n=1. One edge after release EO_n=0 and GS_n stays 1.
- Single request:
  - Stimulus: I_n[5] falls; after the grant, ACK=1 for one cycle.
  - Response: GS_n=0 and A_n=3'b010 at edge 3, held indefinitely without ACK. After ACK, A_n=3'b111, GS_n=1, EO_n=0.
- Priority and spacing:
  - Stimulus: I_n[2] and I_n[6] fall in the same cycle.
  - Response: first grant A_n=3'b001. After ACK, one cycle with GS_n=1, then A_n=3'b101.
- Level held low:
  - Stimulus: I_n[3] held low through its ACK. Then raise it and drop it again.
  - Response: no second grant while it stays low. The new fall produces a new grant with A_n=3'b100.
- ACK/edge collision:
  - Stimulus: I_n[4] pulses so its synchronized fall coincides with the ACK of code 4.
  - Response: a second grant with A_n=3'b011 follows after one idle cycle.
- Abort:
  - Stimulus: EI_n=1 during HOLD of code 7, then EI_n=0.
  - Response: while EI_n=1, GS_n=1, A_n=3'b111, EO_n=1. With EI_n=0, code 7 is re-granted as A_n=3'b000.
